// File: rtl/lcd_pkg.sv
// Shared constants for the LCD bus receiver: opcode masks, error bits,
// buffer fill value, line base addresses and FSM state encodings.
package lcd_pkg;

  localparam logic [7:0] SPACE      = 8'h20;
  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;

  // Instruction opcodes as (mask, value) pairs, listed in decode priority order.
  localparam logic [7:0] OP_DDRAM_MASK = 8'h80;
  localparam logic [7:0] OP_DDRAM_VAL  = 8'h80;
  localparam logic [7:0] OP_CGRAM_MASK = 8'hC0;
  localparam logic [7:0] OP_CGRAM_VAL  = 8'h40;
  localparam logic [7:0] OP_SHIFT_MASK = 8'hF0;
  localparam logic [7:0] OP_SHIFT_VAL  = 8'h10;
  localparam logic [7:0] OP_DISP_MASK  = 8'hF8;
  localparam logic [7:0] OP_DISP_VAL   = 8'h08;
  localparam logic [7:0] OP_ENTRY_MASK = 8'hFC;
  localparam logic [7:0] OP_ENTRY_VAL  = 8'h04;
  localparam logic [7:0] OP_HOME_MASK  = 8'hFE;
  localparam logic [7:0] OP_HOME_VAL   = 8'h02;
  localparam logic [7:0] OP_CLEAR_MASK = 8'hFF;
  localparam logic [7:0] OP_CLEAR_VAL  = 8'h01;

  localparam int unsigned ERR_READ = 0;
  localparam int unsigned ERR_BUSY = 1;
  localparam int unsigned ERR_ADDR = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic logic op_match(input logic [7:0] d, input logic [7:0] mask,
                                    input logic [7:0] val);
    return (d & mask) == val;
  endfunction

  // Only the first 16 columns of each of the two lines exist.
  function automatic logic ddram_legal(input logic [6:0] a);
    return (a[6:4] == LINE0_BASE[6:4]) || (a[6:4] == LINE1_BASE[6:4]);
  endfunction

endpackage

// File: rtl/lcd_addr_step.sv
// Cursor step across the two 16-column lines, wrapping line to line.
module lcd_addr_step
  import lcd_pkg::*;
(
  input  logic [6:0] addr,
  input  logic       incr,
  output logic [6:0] next_addr
);

  // Wrap at the end of each line into the other line, otherwise +/-1.
  always_comb begin
    next_addr = addr;
    if (incr) begin
      if (addr == (LINE0_BASE + 7'h0F))      next_addr = LINE1_BASE;
      else if (addr == (LINE1_BASE + 7'h0F)) next_addr = LINE0_BASE;
      else                                   next_addr = addr + 7'd1;
    end else begin
      if (addr == LINE0_BASE)                next_addr = LINE1_BASE + 7'h0F;
      else if (addr == LINE1_BASE)           next_addr = LINE0_BASE + 7'h0F;
      else                                   next_addr = addr - 7'd1;
    end
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780-style bus receiver: decodes write strobes on the falling edge of
// LCD_E into a 2x16 character buffer, cursor and display state.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       incr_mode,
  output logic       busy,
  output logic       wr_pulse,
  output logic [2:0] err
);

  logic        e_q, rs_q, rw_q;
  logic [7:0]  data_q;
  logic [0:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [6:0]  cursor_q, cursor_d;
  logic        disp_q, disp_d;
  logic        incr_q, incr_d;
  logic        wr_q, wr_d;
  logic [2:0]  err_q, err_d;
  logic [7:0]  rd_q, rd_d;
  logic [7:0]  buf_q [32];
  logic [7:0]  buf_d [32];
  logic        strobe;
  logic [6:0]  step_addr;

  // RS/RW/DATA are taken from the registered copies, i.e. while E was high.
  assign strobe = e_q & ~LCD_E;

  lcd_addr_step u_step (
    .addr      (cursor_q),
    .incr      (incr_q),
    .next_addr (step_addr)
  );

  // Next-state: clear timer, strobe classification and instruction/data decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    disp_d   = disp_q;
    incr_d   = incr_q;
    wr_d     = 1'b0;
    err_d    = err_q;
    buf_d    = buf_q;
    rd_d     = buf_q[rd_addr];

    if (state_q == ST_CLEAR) begin
      if (cnt_q == 32'd0) state_d = ST_IDLE;
      else                cnt_d   = cnt_q - 32'd1;
    end

    if (strobe) begin
      if (rw_q) begin
        err_d[ERR_READ] = 1'b1;
      end else if (state_q == ST_CLEAR) begin
        err_d[ERR_BUSY] = 1'b1;
      end else if (rs_q) begin
        buf_d[{cursor_q[6], cursor_q[3:0]}] = data_q;
        wr_d     = 1'b1;
        cursor_d = step_addr;
      end else if (op_match(data_q, OP_DDRAM_MASK, OP_DDRAM_VAL)) begin
        if (ddram_legal(data_q[6:0])) cursor_d = data_q[6:0];
        else                          err_d[ERR_ADDR] = 1'b1;
      end else if (op_match(data_q, OP_CGRAM_MASK, OP_CGRAM_VAL) ||
                   op_match(data_q, OP_SHIFT_MASK, OP_SHIFT_VAL)) begin
        // Accepted, no modelled effect.
      end else if (op_match(data_q, OP_DISP_MASK, OP_DISP_VAL)) begin
        disp_d = data_q[2];
      end else if (op_match(data_q, OP_ENTRY_MASK, OP_ENTRY_VAL)) begin
        incr_d = data_q[1];
      end else if (op_match(data_q, OP_HOME_MASK, OP_HOME_VAL)) begin
        cursor_d = LINE0_BASE;
      end else if (op_match(data_q, OP_CLEAR_MASK, OP_CLEAR_VAL)) begin
        // Buffer is blanked at entry; busy then holds for CLR_CYCLES cycles.
        state_d  = ST_CLEAR;
        cnt_d    = CLR_CYCLES - 32'd1;
        cursor_d = LINE0_BASE;
        incr_d   = 1'b1;
        for (int i = 0; i < 32; i++) buf_d[i] = SPACE;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      data_q   <= 8'h00;
      state_q  <= ST_IDLE;
      cnt_q    <= 32'd0;
      cursor_q <= LINE0_BASE;
      disp_q   <= 1'b0;
      incr_q   <= 1'b1;
      wr_q     <= 1'b0;
      err_q    <= 3'b000;
      rd_q     <= SPACE;
      for (int i = 0; i < 32; i++) buf_q[i] <= SPACE;
    end else begin
      e_q      <= LCD_E;
      rs_q     <= LCD_RS;
      rw_q     <= LCD_RW;
      data_q   <= LCD_DATA;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cursor_q <= cursor_d;
      disp_q   <= disp_d;
      incr_q   <= incr_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      for (int i = 0; i < 32; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign rd_char     = rd_q;
  assign cursor_addr = cursor_q;
  assign display_on  = disp_q;
  assign incr_mode   = incr_q;
  assign busy        = (state_q == ST_CLEAR);
  assign wr_pulse    = wr_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed self-checking bench for lcd_bus_receiver.
module tb_lcd_bus_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       LCD_E = 1'b0;
  logic       LCD_RS = 1'b0;
  logic       LCD_RW = 1'b0;
  logic [7:0] LCD_DATA = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic [6:0] cursor_addr;
  logic       display_on, incr_mode, busy, wr_pulse;
  logic [2:0] err;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic last_wr;
  logic [7:0] v;

  lcd_bus_receiver #(.CLR_CYCLES(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .LCD_E       (LCD_E),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .LCD_DATA    (LCD_DATA),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .cursor_addr (cursor_addr),
    .display_on  (display_on),
    .incr_mode   (incr_mode),
    .busy        (busy),
    .wr_pulse    (wr_pulse),
    .err         (err)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One full bus write; returns at the first negedge where its effect is visible.
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clock);
    LCD_E = 1'b1; LCD_RS = rs; LCD_RW = rw; LCD_DATA = d;
    @(negedge clock);
    LCD_E = 1'b0;
    @(negedge clock);
    last_wr = wr_pulse;
    if (wr_pulse) pulses++;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] val);
    @(negedge clock);
    rd_addr = a;
    @(negedge clock);
    val = rd_char;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({cursor_addr, display_on, incr_mode, busy, wr_pulse, err, rd_char} !==
        {7'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 8'h20}) begin
      errors++;
      $display("FAIL reset_state: got cur=%h disp=%b inc=%b busy=%b wr=%b err=%b rd=%h",
               cursor_addr, display_on, incr_mode, busy, wr_pulse, err, rd_char);
    end
  endtask

  task automatic test_write_line0;
    pulses = 0;
    strobe(1'b0, 1'b0, 8'h80);
    strobe(1'b1, 1'b0, 8'h47);
    strobe(1'b1, 1'b0, 8'h4F);
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL wr_pulse_count: got %0d want 2", pulses); end
    checks++;
    if (cursor_addr !== 7'h02) begin
      errors++; $display("FAIL cursor_after_GO: got %h want 02", cursor_addr);
    end
    rd(5'd0, v);
    checks++;
    if (v !== 8'h47) begin errors++; $display("FAIL buf0_G: got %h want 47", v); end
    rd(5'd1, v);
    checks++;
    if (v !== 8'h4F) begin errors++; $display("FAIL buf1_O: got %h want 4f", v); end
  endtask

  task automatic test_line_wrap;
    strobe(1'b0, 1'b0, 8'h8F);
    strobe(1'b1, 1'b0, 8'h41);
    strobe(1'b1, 1'b0, 8'h42);
    checks++;
    if (cursor_addr !== 7'h41) begin
      errors++; $display("FAIL cursor_wrap_0F: got %h want 41", cursor_addr);
    end
    rd(5'd15, v);
    checks++;
    if (v !== 8'h41) begin errors++; $display("FAIL buf15_A: got %h want 41", v); end
    rd(5'd16, v);
    checks++;
    if (v !== 8'h42) begin errors++; $display("FAIL buf16_B: got %h want 42", v); end
    strobe(1'b0, 1'b0, 8'hCF);
    strobe(1'b1, 1'b0, 8'h21);
    checks++;
    if (cursor_addr !== 7'h00) begin
      errors++; $display("FAIL cursor_wrap_4F: got %h want 00", cursor_addr);
    end
  endtask

  task automatic test_decrement;
    strobe(1'b0, 1'b0, 8'h04);
    checks++;
    if (incr_mode !== 1'b0) begin errors++; $display("FAIL incr_mode_dec: got %b want 0", incr_mode); end
    strobe(1'b0, 1'b0, 8'h80);
    strobe(1'b1, 1'b0, 8'h5A);
    checks++;
    if (cursor_addr !== 7'h4F) begin
      errors++; $display("FAIL cursor_dec_00: got %h want 4f", cursor_addr);
    end
    rd(5'd0, v);
    checks++;
    if (v !== 8'h5A) begin errors++; $display("FAIL buf0_Z: got %h want 5a", v); end
    strobe(1'b0, 1'b0, 8'hC0);
    strobe(1'b1, 1'b0, 8'h59);
    checks++;
    if (cursor_addr !== 7'h0F) begin
      errors++; $display("FAIL cursor_dec_40: got %h want 0f", cursor_addr);
    end
    rd(5'd16, v);
    checks++;
    if (v !== 8'h59) begin errors++; $display("FAIL buf16_Y: got %h want 59", v); end
  endtask

  task automatic test_clear;
    int busy_cnt;
    int bad;
    bit fell;
    strobe(1'b0, 1'b0, 8'h01);
    busy_cnt = busy ? 1 : 0;
    fell = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clock);
          if (busy) busy_cnt++;
          else if (busy_cnt > 0) begin fell = 1'b1; break; end
        end
      end
      begin
        repeat (5) @(negedge clock);
        strobe(1'b0, 1'b0, 8'h0C);
      end
    join
    checks++;
    if (!fell || busy_cnt != 32) begin
      errors++; $display("FAIL busy_cycles: got %0d (fell=%0b) want 32", busy_cnt, fell);
    end
    checks++;
    if (err !== 3'b010) begin errors++; $display("FAIL err_busy: got %b want 010", err); end
    checks++;
    if (display_on !== 1'b0) begin
      errors++; $display("FAIL busy_strobe_ignored: display_on got %b want 0", display_on);
    end
    checks++;
    if ({cursor_addr, incr_mode} !== {7'h00, 1'b1}) begin
      errors++; $display("FAIL clear_cursor: got cur=%h inc=%b want 00/1", cursor_addr, incr_mode);
    end
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      rd(a[4:0], v);
      if (v !== 8'h20) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clear_buffer: got %0d non-space entries want 0", bad); end
  endtask

  task automatic test_errors;
    strobe(1'b0, 1'b0, 8'h85);
    strobe(1'b0, 1'b0, 8'h95);
    checks++;
    if ({err, cursor_addr} !== {3'b110, 7'h05}) begin
      errors++; $display("FAIL err_addr: got err=%b cur=%h want 110/05", err, cursor_addr);
    end
    strobe(1'b0, 1'b1, 8'h0C);
    checks++;
    if ({err, display_on} !== {3'b111, 1'b0}) begin
      errors++; $display("FAIL err_read: got err=%b disp=%b want 111/0", err, display_on);
    end
    strobe(1'b0, 1'b0, 8'h0C);
    checks++;
    if (display_on !== 1'b1) begin errors++; $display("FAIL display_on: got %b want 1", display_on); end
  endtask

  task automatic test_reset_during_clear;
    strobe(1'b1, 1'b0, 8'h33);
    strobe(1'b0, 1'b0, 8'h01);
    repeat (9) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_cycle10: got %b want 1", busy); end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, err, cursor_addr, display_on, incr_mode, wr_pulse, rd_char} !==
        {1'b0, 3'b000, 7'h00, 1'b0, 1'b1, 1'b0, 8'h20}) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b err=%b cur=%h disp=%b inc=%b wr=%b rd=%h",
               busy, err, cursor_addr, display_on, incr_mode, wr_pulse, rd_char);
    end
    reset = 1'b1;
    repeat (40) @(negedge clock);
    checks++;
    if ({busy, err, cursor_addr} !== {1'b0, 3'b000, 7'h00}) begin
      errors++; $display("FAIL reset_no_resume: got busy=%b err=%b cur=%h", busy, err, cursor_addr);
    end
  endtask

  initial begin
    test_reset();
    test_write_line0();
    test_line_wrap();
    test_decrement();
    test_clear();
    test_errors();
    test_reset_during_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
